// File: rtl/bp_mem_arb_pkg.sv
// Shared types and helpers for the instruction/data SRAM arbiter.
// Imported by the grant core and the arbiter top.
package bp_mem_arb_pkg;

   localparam int unsigned MaxDataWidth = 1024;
   localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

   typedef enum logic [1:0] {
      OWNER_INSTR = 2'd0,
      OWNER_DATA  = 2'd1,
      OWNER_NONE  = 2'd2
   } owner_e;

   typedef enum logic {
      ARB_RR        = 1'b0,
      ARB_DATA_PRIO = 1'b1
   } arb_mode_e;

   typedef struct packed {
      owner_e owner;
      logic   err;
   } resp_tag_t;

   // Each byte strobe becomes eight mask bits; callers truncate to their data width.
   function automatic logic [MaxDataWidth-1:0] strb_to_mask(input logic [MaxStrbWidth-1:0] strb);
      logic [MaxDataWidth-1:0] mask;
      mask = '0;
      for (int i = 0; i < int'(MaxStrbWidth); i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/bp_mem_arb_core.sv
// Two-input grant logic for the shared SRAM: round-robin or data-priority
// with a starvation guard that forces an instruction grant.
module bp_mem_arb_core
   import bp_mem_arb_pkg::*;
#(
   parameter arb_mode_e   ArbMode   = ARB_RR,
   parameter int unsigned MaxStarve = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic instr_req_i,
   input  logic data_req_i,
   output logic instr_gnt_o,
   output logic data_gnt_o
);

   localparam int unsigned StarveW = 4;

   owner_e             rr_last_q, rr_last_d;
   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
   logic               instr_win;

   always_comb begin
      instr_win = 1'b0;
      if (instr_req_i && !data_req_i) begin
         instr_win = 1'b1;
      end else if (instr_req_i && data_req_i) begin
         if (ArbMode == ARB_DATA_PRIO) begin
            instr_win = (starve_cnt_q == StarveW'(MaxStarve));
         end else begin
            instr_win = (rr_last_q == OWNER_DATA);
         end
      end

      instr_gnt_o = instr_win;
      data_gnt_o  = data_req_i && !instr_win;

      rr_last_d = rr_last_q;
      if (instr_gnt_o) begin
         rr_last_d = OWNER_INSTR;
      end else if (data_gnt_o) begin
         rr_last_d = OWNER_DATA;
      end

      // Only an unbroken run of denied instruction requests builds up pressure.
      starve_cnt_d = '0;
      if (instr_req_i && !instr_gnt_o) begin
         starve_cnt_d = (starve_cnt_q == StarveW'(MaxStarve)) ? starve_cnt_q
                                                              : starve_cnt_q + StarveW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_last_q    <= OWNER_DATA;
         starve_cnt_q <= '0;
      end else begin
         rr_last_q    <= rr_last_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/bp_mem_arbiter.sv
// Shares one single-port SRAM between the instruction and data ports,
// routing each response to the port granted in the previous cycle.
module bp_mem_arbiter
   import bp_mem_arb_pkg::*;
#(
   parameter int unsigned NumWords  = 1 << 17,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter arb_mode_e   ArbMode   = ARB_RR,
   parameter int unsigned MaxStarve = 4,
   localparam int unsigned StrbWidth = DataWidth / 8,
   localparam int unsigned MemAw     = $clog2(NumWords)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 instr_req_i,
   output logic                 instr_gnt_o,
   input  logic [AddrWidth-1:0] instr_addr_i,
   input  logic [DataWidth-1:0] instr_wdata_i,
   input  logic [StrbWidth-1:0] instr_strb_i,
   input  logic                 instr_we_i,
   output logic                 instr_rvalid_o,
   output logic [DataWidth-1:0] instr_rdata_o,
   output logic                 instr_err_o,
   input  logic                 data_req_i,
   output logic                 data_gnt_o,
   input  logic [AddrWidth-1:0] data_addr_i,
   input  logic [DataWidth-1:0] data_wdata_i,
   input  logic [StrbWidth-1:0] data_strb_i,
   input  logic                 data_we_i,
   output logic                 data_rvalid_o,
   output logic [DataWidth-1:0] data_rdata_o,
   output logic                 data_err_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [MemAw-1:0]     mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [DataWidth-1:0] mem_wmask_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   localparam int unsigned WordW = AddrWidth - 3;

   logic [WordW-1:0]     instr_word, data_word;
   logic                 instr_in_range, data_in_range;
   logic [StrbWidth-1:0] strb_sel;
   logic [DataWidth-1:0] resp_rdata;
   logic [DataWidth-1:0] instr_rdata_q, instr_rdata_d, data_rdata_q, data_rdata_d;
   resp_tag_t            tag_q, tag_d;
   logic                 unused_addr_lsbs;

   bp_mem_arb_core #(
      .ArbMode   (ArbMode),
      .MaxStarve (MaxStarve)
   ) u_core (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .instr_req_i (instr_req_i),
      .data_req_i  (data_req_i),
      .instr_gnt_o (instr_gnt_o),
      .data_gnt_o  (data_gnt_o)
   );

   // Byte-offset bits are carried by the strobes, not the address.
   assign unused_addr_lsbs = ^{instr_addr_i[2:0], data_addr_i[2:0]};

   always_comb begin
      instr_word     = instr_addr_i[AddrWidth-1:3];
      data_word      = data_addr_i[AddrWidth-1:3];
      instr_in_range = instr_word < WordW'(NumWords);
      data_in_range  = data_word < WordW'(NumWords);

      // Out-of-range winners are granted but never reach the SRAM.
      mem_req_o   = (instr_gnt_o && instr_in_range) || (data_gnt_o && data_in_range);
      mem_we_o    = data_gnt_o ? data_we_i : instr_we_i;
      mem_addr_o  = data_gnt_o ? data_word[MemAw-1:0] : instr_word[MemAw-1:0];
      mem_wdata_o = data_gnt_o ? data_wdata_i : instr_wdata_i;
      strb_sel    = data_gnt_o ? data_strb_i : instr_strb_i;
      mem_wmask_o = DataWidth'(strb_to_mask(MaxStrbWidth'(strb_sel)));

      tag_d = '{owner: OWNER_NONE, err: 1'b0};
      if (instr_gnt_o) begin
         tag_d = '{owner: OWNER_INSTR, err: !instr_in_range};
      end else if (data_gnt_o) begin
         tag_d = '{owner: OWNER_DATA, err: !data_in_range};
      end
   end

   // Response cycle: the SRAM data flows straight through; otherwise the last value holds.
   always_comb begin
      resp_rdata     = tag_q.err ? '0 : mem_rdata_i;
      instr_rvalid_o = (tag_q.owner == OWNER_INSTR);
      data_rvalid_o  = (tag_q.owner == OWNER_DATA);
      instr_err_o    = instr_rvalid_o && tag_q.err;
      data_err_o     = data_rvalid_o && tag_q.err;
      instr_rdata_o  = instr_rvalid_o ? resp_rdata : instr_rdata_q;
      data_rdata_o   = data_rvalid_o ? resp_rdata : data_rdata_q;
      instr_rdata_d  = instr_rdata_o;
      data_rdata_d   = data_rdata_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_q         <= '{owner: OWNER_NONE, err: 1'b0};
         instr_rdata_q <= '0;
         data_rdata_q  <= '0;
      end else begin
         tag_q         <= tag_d;
         instr_rdata_q <= instr_rdata_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Scoreboard bench for bp_mem_arbiter: a round-robin instance is fully checked,
// a data-priority instance shares its inputs for grant-sequence checks.
module tb_bp_mem_arbiter;
   import bp_mem_arb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        instr_req_i = 1'b0, data_req_i = 1'b0;
   logic [63:0] instr_addr_i = '0, data_addr_i = '0;
   logic [63:0] instr_wdata_i = '0, data_wdata_i = '0;
   logic [7:0]  instr_strb_i = '0, data_strb_i = '0;
   logic        instr_we_i = 1'b0, data_we_i = 1'b0;
   logic [63:0] mem_rdata_i = '0;

   logic        rr_instr_gnt, rr_data_gnt, rr_instr_rvalid, rr_data_rvalid, rr_instr_err, rr_data_err;
   logic [63:0] rr_instr_rdata, rr_data_rdata, rr_mem_wdata, rr_mem_wmask;
   logic        rr_mem_req, rr_mem_we;
   logic [16:0] rr_mem_addr;

   logic        dp_instr_gnt, dp_data_gnt, dp_instr_rvalid, dp_data_rvalid, dp_instr_err, dp_data_err;
   logic [63:0] dp_instr_rdata, dp_data_rdata, dp_mem_wdata, dp_mem_wmask;
   logic        dp_mem_req, dp_mem_we;
   logic [16:0] dp_mem_addr;

   typedef struct {
      logic        is_data;
      logic        err;
      logic [63:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] pending_rdata = '0;

   always #5 clk_i = ~clk_i;

   bp_mem_arbiter #(.ArbMode(ARB_RR)) u_rr (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .instr_req_i (instr_req_i), .instr_gnt_o (rr_instr_gnt), .instr_addr_i (instr_addr_i),
      .instr_wdata_i (instr_wdata_i), .instr_strb_i (instr_strb_i), .instr_we_i (instr_we_i),
      .instr_rvalid_o (rr_instr_rvalid), .instr_rdata_o (rr_instr_rdata), .instr_err_o (rr_instr_err),
      .data_req_i (data_req_i), .data_gnt_o (rr_data_gnt), .data_addr_i (data_addr_i),
      .data_wdata_i (data_wdata_i), .data_strb_i (data_strb_i), .data_we_i (data_we_i),
      .data_rvalid_o (rr_data_rvalid), .data_rdata_o (rr_data_rdata), .data_err_o (rr_data_err),
      .mem_req_o (rr_mem_req), .mem_we_o (rr_mem_we), .mem_addr_o (rr_mem_addr),
      .mem_wdata_o (rr_mem_wdata), .mem_wmask_o (rr_mem_wmask), .mem_rdata_i (mem_rdata_i)
   );

   bp_mem_arbiter #(.ArbMode(ARB_DATA_PRIO), .MaxStarve(4)) u_dp (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .instr_req_i (instr_req_i), .instr_gnt_o (dp_instr_gnt), .instr_addr_i (instr_addr_i),
      .instr_wdata_i (instr_wdata_i), .instr_strb_i (instr_strb_i), .instr_we_i (instr_we_i),
      .instr_rvalid_o (dp_instr_rvalid), .instr_rdata_o (dp_instr_rdata), .instr_err_o (dp_instr_err),
      .data_req_i (data_req_i), .data_gnt_o (dp_data_gnt), .data_addr_i (data_addr_i),
      .data_wdata_i (data_wdata_i), .data_strb_i (data_strb_i), .data_we_i (data_we_i),
      .data_rvalid_o (dp_data_rvalid), .data_rdata_o (dp_data_rdata), .data_err_o (dp_data_err),
      .mem_req_o (dp_mem_req), .mem_we_o (dp_mem_we), .mem_addr_o (dp_mem_addr),
      .mem_wdata_o (dp_mem_wdata), .mem_wmask_o (dp_mem_wmask), .mem_rdata_i (mem_rdata_i)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive the ports, check grant/memory side, queue the response.
   task automatic applyStimulus(
      input logic ireq, input logic dreq, input logic [63:0] iaddr, input logic [63:0] daddr,
      input logic dwe, input logic [7:0] dstrb, input logic [63:0] dwdata, input logic [63:0] rdata_next,
      input logic exp_ig, input logic exp_dg, input logic exp_mreq, input logic exp_err,
      input logic exp_dp_ig, input logic exp_dp_dg, input logic [16:0] exp_maddr, input logic push);
      exp_t e;
      @(posedge clk_i);
      #2;
      mem_rdata_i   = pending_rdata;
      instr_req_i   = ireq;
      data_req_i    = dreq;
      instr_addr_i  = iaddr;
      data_addr_i   = daddr;
      instr_we_i    = 1'b0;
      instr_strb_i  = 8'hFF;
      instr_wdata_i = '0;
      data_we_i     = dwe;
      data_strb_i   = dstrb;
      data_wdata_i  = dwdata;
      #1;
      checkOutput("rr_instr_gnt", 64'(rr_instr_gnt), 64'(exp_ig));
      checkOutput("rr_data_gnt", 64'(rr_data_gnt), 64'(exp_dg));
      checkOutput("rr_mem_req", 64'(rr_mem_req), 64'(exp_mreq));
      checkOutput("dp_instr_gnt", 64'(dp_instr_gnt), 64'(exp_dp_ig));
      checkOutput("dp_data_gnt", 64'(dp_data_gnt), 64'(exp_dp_dg));
      if (exp_mreq) checkOutput("rr_mem_addr", 64'(rr_mem_addr), 64'(exp_maddr));
      if (push && (exp_ig || exp_dg)) begin
         e.is_data = exp_dg;
         e.err     = exp_err;
         e.rdata   = exp_err ? 64'h0 : rdata_next;
         exp_q.push_back(e);
      end
      pending_rdata = rdata_next;
   endtask

   // Monitor: every response is popped and compared against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_ni && (rr_instr_rvalid || rr_data_rvalid)) begin
            checkOutput("single_rvalid", 64'(rr_instr_rvalid && rr_data_rvalid), 64'h0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_rvalid: got instr=%0b data=%0b, expected none at %0t",
                        rr_instr_rvalid, rr_data_rvalid, $time);
            end else begin
               e = exp_q.pop_front();
               checkOutput("resp_port_is_data", 64'(rr_data_rvalid), 64'(e.is_data));
               if (e.is_data) begin
                  checkOutput("data_err", 64'(rr_data_err), 64'(e.err));
                  checkOutput("data_rdata", rr_data_rdata, e.rdata);
               end else begin
                  checkOutput("instr_err", 64'(rr_instr_err), 64'(e.err));
                  checkOutput("instr_rdata", rr_instr_rdata, e.rdata);
               end
            end
         end
      end
   end

   initial begin
      logic rr_i, dp_i;
      #12;
      checkOutput("reset_instr_rvalid", 64'(rr_instr_rvalid), 64'h0);
      checkOutput("reset_data_rvalid", 64'(rr_data_rvalid), 64'h0);
      checkOutput("reset_instr_rdata", rr_instr_rdata, 64'h0);
      checkOutput("reset_mem_req", 64'(rr_mem_req), 64'h0);
      rst_ni = 1'b1;

      applyStimulus(1, 0, 64'h80, 64'h0, 0, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D,
                    1, 0, 1, 0, 1, 0, 17'h10, 1);

      // Contested stretch: rr alternates (last grant was INSTR), dp gives D,D,D,D,I.
      for (int k = 0; k < 10; k++) begin
         rr_i = (k % 2) == 1;
         dp_i = (k == 4) || (k == 9);
         applyStimulus(1, 1, 64'h100, 64'h200, 0, 8'hFF, 64'h0, 64'hA5A5_0000_0000_0000 | 64'(k),
                       rr_i, !rr_i, 1, 0, dp_i, !dp_i, rr_i ? 17'h20 : 17'h40, 1);
      end

      applyStimulus(0, 1, 64'h0, 64'h28, 1, 8'h0F, 64'h11223344_55667788, 64'h0BAD_0000_0000_0005,
                    0, 1, 1, 0, 0, 1, 17'd5, 1);
      checkOutput("mem_wmask", rr_mem_wmask, 64'h00000000_FFFFFFFF);
      checkOutput("mem_we", 64'(rr_mem_we), 64'h1);
      checkOutput("mem_wdata", rr_mem_wdata, 64'h11223344_55667788);

      applyStimulus(0, 1, 64'h0, 64'h100000, 0, 8'hFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                    0, 1, 0, 1, 0, 1, 17'h0, 1);
      applyStimulus(0, 1, 64'h0, 64'hFFFF8, 0, 8'hFF, 64'h0, 64'h1234_5678_9ABC_DEF0,
                    0, 1, 1, 0, 0, 1, 17'h1FFFF, 1);
      applyStimulus(0, 1, 64'h0, 64'h8000_0000_0000_0000, 0, 8'hFF, 64'h0, 64'h7777_7777_7777_7777,
                    0, 1, 0, 1, 0, 1, 17'h0, 1);
      applyStimulus(1, 0, 64'h100000, 64'h0, 0, 8'h00, 64'h0, 64'h6666_6666_6666_6666,
                    1, 0, 0, 1, 1, 0, 17'h0, 1);
      applyStimulus(1, 0, 64'h80, 64'h0, 0, 8'h00, 64'h0, 64'h5555_AAAA_5555_AAAA,
                    1, 0, 1, 0, 1, 0, 17'h10, 1);

      // Grant issued, then reset pulsed before the response edge: the response must vanish.
      applyStimulus(1, 0, 64'h88, 64'h0, 0, 8'h00, 64'h0, 64'h4444_4444_4444_4444,
                    1, 0, 1, 0, 1, 0, 17'h11, 0);
      #3;
      rst_ni      = 1'b0;
      instr_req_i = 1'b0;
      #2;
      rst_ni = 1'b1;
      #0.5;
      checkOutput("post_reset_instr_rvalid", 64'(rr_instr_rvalid), 64'h0);
      checkOutput("post_reset_instr_rdata", rr_instr_rdata, 64'h0);
      checkOutput("post_reset_data_rdata", rr_data_rdata, 64'h0);
      checkOutput("post_reset_mem_req", 64'(rr_mem_req), 64'h0);
      @(posedge clk_i);
      #1;
      checkOutput("dropped_instr_rvalid", 64'(rr_instr_rvalid), 64'h0);
      checkOutput("dropped_instr_err", 64'(rr_instr_err), 64'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 17'h0, 0);
      end
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_mem_arbiter.md
Name: bp_mem_arbiter

Overview:
- Shares one single-port SRAM (1-cycle registered read latency) between the core's instruction and data memory ports.
- Sits between bp_mem_top's instruction/data req/gnt interfaces and a single sram_mem instance, replacing the constant-grant dual-SRAM arrangement.
- Arbitrates per cycle and routes the read response to the requester granted in the previous cycle.
- Flags out-of-range accesses without touching memory.

Parameters:
- NumWords, 1<<17, SRAM depth in 64-bit words.
- AddrWidth, 64, byte-address width of requester ports.
- DataWidth, 64, data width; StrbWidth = DataWidth/8.
- ArbMode, 0, 0 = round-robin, 1 = data-priority with starvation guard.
- MaxStarve, 4, ArbMode 1 only: consecutive instruction-port denials that force one instruction grant; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i / data_req_i  in  1  request
- instr_gnt_o / data_gnt_o  out  1  grant, combinational, same cycle as request
- instr_addr_i / data_addr_i  in  AddrWidth  byte address
- instr_wdata_i / data_wdata_i  in  DataWidth  write data
- instr_strb_i / data_strb_i  in  StrbWidth  byte strobes
- instr_we_i / data_we_i  in  1  write enable
- instr_rvalid_o / data_rvalid_o  out  1  response valid, one cycle after grant
- instr_rdata_o / data_rdata_o  out  DataWidth  read data
- instr_err_o / data_err_o  out  1  out-of-range flag, valid with rvalid
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  $clog2(NumWords)  SRAM word address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_wmask_o  out  DataWidth  bit mask; each strobe bit replicated 8x
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after mem_req_o

Behaviour:
- Reset values (async on rst_ni low): all rvalid_o = 0, err_o = 0, rdata_o = 0, mem_req_o = 0. rr_last = DATA, so the first contested cycle goes to INSTR. Starvation counter = 0. Response tag = NONE.
- Grant (combinational):
  - At most one gnt_o per cycle; a gnt_o is only asserted with its req_i.
  - Single requester: it is granted.
  - Both requesters, ArbMode 0: grant the port not in rr_last.
  - Both requesters, ArbMode 1: grant DATA unless starve_cnt == MaxStarve, then grant INSTR.
- rr_last updates on every grant.
- starve_cnt:
  - Increments, saturating at MaxStarve, when instr_req_i=1 and instr_gnt_o=0.
  - Clears to 0 on any instruction grant or whenever instr_req_i=0.
- Address decode:
  - word = addr >> 3; low 3 address bits are ignored (strobes carry byte lanes).
  - In range iff word < NumWords. Upper address bits beyond $clog2(NumWords) must be zero.
- Memory drive:
  - Granted and in range: mem_req_o=1; mem_we_o, mem_addr_o, mem_wdata_o and mem_wmask_o come from the winner.
  - Granted and out of range: mem_req_o=0 (no write side effect).
  - No grant: mem_req_o=0; other mem_* outputs are don't-care but driven from INSTR to avoid X.
- Response tag register (captured on grant): {owner, err}, otherwise NONE.
- Next cycle, for tag owner X:
  - X_rvalid_o=1, for reads and writes alike.
  - X_err_o = tag err.
  - X_rdata_o = mem_rdata_i if not err, else 0.
  - The X_rdata_o register holds its value until X's next response.
- The other requester's rvalid_o=0 and its rdata_o is unchanged.
- Back-to-back grants are allowed every cycle (fully pipelined, one outstanding per cycle, no stall).
- Reset asserted mid-operation: a pending response is dropped; no rvalid is issued after reset release for a pre-reset grant.
- req_i deasserting without a grant is legal. No request-hold rule is imposed on requesters.

Decomposition:
- Package bp_mem_arb_pkg:
  - owner_e {OWNER_INSTR, OWNER_DATA, OWNER_NONE}.
  - arb_mode_e {ARB_RR=0, ARB_DATA_PRIO=1}.
  - strb_to_mask function.
  - resp_tag_t struct {owner_e owner; logic err;}.
- One sub-module bp_mem_arb_core: two-input grant logic, rr_last and starve_cnt. Address decode, muxing and response routing stay in the top.

Test Plan:
- Reset release, instr-only read at 0x80 with mem_rdata_i=0xDEADBEEF_CAFEF00D next cycle → instr_gnt_o=1, mem_addr_o=0x10; next cycle instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF_CAFEF00D, data_rvalid_o=0.
- ArbMode 0, both requesting for 6 cycles → grants alternate I,D,I,D,I,D; each rvalid lands one cycle after its grant on the correct port.
- ArbMode 1, MaxStarve=4, both requesting continuously → D,D,D,D,I repeating; starve_cnt returns to 0 after each instruction grant.
- Data write strb=0x0F, wdata=0x11223344_55667788 at word 5 → mem_wmask_o=0x00000000_FFFFFFFF, mem_we_o=1; next cycle data_rvalid_o=1, data_err_o=0.
- Data read at word address NumWords (0x20000<<3) → gnt=1, mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
- Grant issued, rst_ni pulsed low before the next clock edge → after release no rvalid_o asserted and all outputs hold reset values.
